// File: rtl/phase_sweep_ctrl_if.sv
// Phase sweep controller bus: configuration offer, start/stop
// controls, sample stream (valid/ready) and status flags.
// master = sweep client (drives config, controls, out_ready)
// slave  = phase_sweep_ctrl (drives samples and status)
interface phase_sweep_ctrl_if #(
    parameter int W  = 10,
    parameter int DW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_div;
    logic          cfg_mode;
    logic [W-1:0]  cfg_lo;
    logic [W-1:0]  cfg_hi;
    logic [7:0]    cfg_cycles;
    logic          start;
    logic          stop;
    logic [W-1:0]  out_phase;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_mode, cfg_lo, cfg_hi,
        output cfg_cycles, start, stop, out_ready,
        input  cfg_ready, out_phase, out_valid, busy, done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_mode, cfg_lo, cfg_hi,
        input  cfg_cycles, start, stop, out_ready,
        output cfg_ready, out_phase, out_valid, busy, done,
        output cfg_err
    );
endinterface

// File: rtl/phase_sweep_ctrl.sv
// Phase sweep generator: emits signed sawtooth/triangle phase
// samples between stored limits, one step every div+1 clocks.
// Ports: clk, rst (async, active-high), bus (slave modport).
module phase_sweep_ctrl #(
    parameter int W  = 10,
    parameter int DW = 8
) (
    input logic               clk,
    input logic               rst,
    phase_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  phase_q, phase_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dn_q, dn_d;
    logic [DW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [7:0]    cyc_q, cyc_d;
    logic          err_q, err_d;

    logic          slot_free;
    logic [W-1:0]  nxt_ph;
    logic          nxt_dn;
    logic          wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dn_q    <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
            div_q   <= DW'(9);
            mode_q  <= 1'b1;
            lo_q    <= {1'b1, {(W-1){1'b0}}};
            hi_q    <= {1'b0, {(W-1){1'b1}}};
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dn_q    <= dn_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dn_d    = dn_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cyc_d   = cyc_q;
        err_d   = err_q;

        slot_free = !valid_q || bus.out_ready;

        // Next sample; only equality tests are needed because the
        // phase never leaves [lo,hi], so +1/-1 cannot wrap.
        nxt_ph = phase_q + W'(1);
        nxt_dn = dn_q;
        wrap   = 1'b0;
        if (!mode_q) begin
            if (phase_q == hi_q) begin
                nxt_ph = lo_q;
                wrap   = 1'b1;
            end
        end else if (!dn_q) begin
            if (phase_q == hi_q) begin
                nxt_ph = hi_q - W'(1);
                // hi-1 == lo: the fall reaches lo in one step,
                // so the period ends here and we keep rising.
                if (nxt_ph == lo_q) wrap   = 1'b1;
                else                nxt_dn = 1'b1;
            end
        end else begin
            nxt_ph = phase_q - W'(1);
            if (nxt_ph == lo_q) begin
                nxt_dn = 1'b0;
                wrap   = 1'b1;
            end
        end

        // Accepted sample frees the slot unless a step refills it.
        if (valid_q && bus.out_ready) valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    div_d  = bus.cfg_div;
                    mode_d = bus.cfg_mode;
                    lo_d   = bus.cfg_lo;
                    hi_d   = bus.cfg_hi;
                    cyc_d  = bus.cfg_cycles;
                    err_d  = $signed(bus.cfg_lo) >=
                             $signed(bus.cfg_hi);
                end
                if (bus.start && !bus.stop && !err_q) begin
                    phase_d = lo_q;
                    dn_d    = 1'b0;
                    pre_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = DRAIN;
                end else if (pre_q != div_q) begin
                    pre_d = pre_q + DW'(1);
                end else if (slot_free) begin
                    pre_d   = '0;
                    phase_d = nxt_ph;
                    dn_d    = nxt_dn;
                    valid_d = 1'b1;
                    if (wrap) begin
                        if (cyc_q != 8'd0 &&
                            cnt_q + 8'd1 == cyc_q)
                            state_d = DRAIN;
                        else if (cnt_q != 8'hFF)
                            cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (!valid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready = (state_q == IDLE);
        bus.out_phase = phase_q;
        bus.out_valid = valid_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.cfg_err   = err_q;
    end
endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 Parameter W, default 10, output phase width (signed two's complement).
REQ-002 Parameter DW, default 8, prescaler divider width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cfg_valid  in  1  config offer; cfg_ready  out  1  config accept (high only in IDLE).
REQ-006 cfg_div  in  DW  step every cfg_div+1 clocks; cfg_mode  in  1  0=sawtooth, 1=triangle.
REQ-007 cfg_lo, cfg_hi  in  W  signed sweep limits; cfg_cycles  in  8  periods to run, 0=continuous.
REQ-008 start  in  1  begin sweep; stop  in  1  abort sweep.
REQ-009 out_phase  out  W  current phase sample; out_valid  out  1; out_ready  in  1  (valid/ready handshake).
REQ-010 busy  out  1  sweep active; done  out  1  one-cycle end pulse; cfg_err  out  1  stored config invalid.

Function
REQ-011 States SHALL be IDLE, RUN, DRAIN; cfg_ready = (state==IDLE).
REQ-012 Config SHALL load on cfg_valid&&cfg_ready; cfg_err SHALL update same edge to (cfg_lo >= cfg_hi, signed).
REQ-013 IDLE + start + !stop + !cfg_err: out_phase<=lo, dir<=up, prescaler<=0, period count<=0, out_valid<=1, busy<=1, -> RUN.
REQ-014 start with cfg_err=1, or start while busy, SHALL be ignored; start&&stop in IDLE: stay IDLE.
REQ-015 RUN: prescaler SHALL count 0..cfg_div; step SHALL occur at terminal count only if slot free (out_valid==0 or out_ready==1 this cycle); otherwise prescaler holds at terminal count.
REQ-016 Each step SHALL load new out_phase and set out_valid=1; out_valid SHALL clear on out_ready with no step that cycle; no sample dropped or duplicated.
REQ-017 Sawtooth step: phase==hi -> lo (period completion), else +1.
REQ-018 Triangle up: phase==hi -> dir=down, phase=hi-1, else +1; down: phase==lo+1... precisely: down and phase-1==lo -> phase=lo, dir=up (period completion); else -1.
REQ-019 Arithmetic SHALL be signed W-bit; phase SHALL never leave [lo,hi].
REQ-020 Period completion with cfg_cycles!=0 and count+1==cfg_cycles: step SHALL be emitted, then -> DRAIN; else count+1 (saturating at 255 when cfg_cycles==0).
REQ-021 stop in RUN SHALL win over a same-cycle step: no step, -> DRAIN.
REQ-022 DRAIN: wait until out_valid==0 (pending sample accepted), then done=1 one cycle, busy<=0, -> IDLE.
REQ-023 out_phase SHALL hold last value in IDLE; cfg_valid outside IDLE ignored.

Reset
REQ-024 rst SHALL immediately force: IDLE, out_phase=0, out_valid=0, busy=0, done=0, dir=up, prescaler=0, count=0, cfg_div=9, cfg_mode=1, cfg_lo=-512, cfg_hi=511, cfg_cycles=0, cfg_err=0.
REQ-025 rst mid-sweep SHALL abort without done pulse; pending sample lost.

Verification
REQ-026 Reset, start, out_ready=1 -> first sample -512, then +1 every 10 clocks, at 511 turns down to 510.
REQ-027 cfg lo=0 hi=3 mode=1 div=0 cycles=2, out_ready=1, start -> 0,1,2,3,2,1,0,1,2,3,2,1,0, done pulse, busy low.
REQ-028 Same cfg mode=0 cycles=1 -> 0,1,2,3,0, done.
REQ-029 div=0, out_ready=0 for 20 cycles mid-sweep -> out_phase/out_valid held stable; release -> next values consecutive, none skipped.
REQ-030 cfg lo=5 hi=5 -> cfg_err=1; start -> busy stays 0; stop with pending unaccepted sample -> DRAIN until accepted, then done.
REQ-031 rst asserted mid-RUN between clock edges -> outputs at reset values before next edge, no done.
